// File: rtl/alu_exec.sv
// alu_exec: ALU with single-cycle logic/arith/shift ops and iterative
// 32-step unsigned shift-add multiply and restoring divide.
//
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops complete from here
//   MUL   | one multiplier bit per cycle, 32 cycles
//   DIV   | one quotient bit per cycle, 32 cycles
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             invalid
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULT = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_next;
    logic             accept;
    logic             last_iter;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor
    logic [WIDTH-1:0] acc_hi;   // partial product high word or remainder
    logic [WIDTH-1:0] acc_lo;   // remaining multiplier bits or quotient
    logic [WIDTH-1:0] acc_hi_n;
    logic [WIDTH-1:0] acc_lo_n;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_fit;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_invalid;

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: iterative ops leave IDLE, divide-by-zero stays single-cycle
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_iter  = (cnt == '0);
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (alucontrol == OP_MULT)
                        state_next = MUL;
                    else if (alucontrol == OP_DIV && b != '0)
                        state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (last_iter) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle result from the live inputs at the accepting edge
    always_comb begin
        sc_result  = '0;
        sc_hi      = '0;
        sc_invalid = 1'b0;
        case (alucontrol)
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_ADD:  sc_result = a + b;
            OP_SUB:  sc_result = a - b;
            OP_SLL:  sc_result = a << b[CW-1:0];
            OP_SRL:  sc_result = a >> b[CW-1:0];
            OP_NOT:  sc_result = ~a;
            OP_DIV: begin
                // only reached with b == 0
                sc_result = '1;
                sc_hi     = a;
            end
            OP_MULT: sc_result = '0;
            default: sc_invalid = 1'b1;
        endcase
    end

    // One shift-add or restoring-subtract step per cycle
    always_comb begin
        acc_hi_n  = acc_hi;
        acc_lo_n  = acc_lo;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_fit   = (div_shift >= {1'b0, opnd});
        if (state == MUL) begin
            acc_hi_n = mul_sum[WIDTH:1];
            acc_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            // when it fits the true difference is below 2^WIDTH
            acc_hi_n = div_fit ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
            acc_lo_n = {acc_lo[WIDTH-2:0], div_fit};
        end
    end

    // Operand capture, iteration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            result  <= '0;
            hi      <= '0;
            zero    <= 1'b0;
            done    <= 1'b0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (state_next == MUL) begin
                            opnd   <= a;
                            acc_hi <= '0;
                            acc_lo <= b;
                            cnt    <= LAST_ITER;
                        end else if (state_next == DIV) begin
                            opnd   <= b;
                            acc_hi <= '0;
                            acc_lo <= a;
                            cnt    <= LAST_ITER;
                        end else begin
                            result  <= sc_result;
                            hi      <= sc_hi;
                            zero    <= (sc_result == '0);
                            invalid <= sc_invalid;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi <= acc_hi_n;
                    acc_lo <= acc_lo_n;
                    cnt    <= cnt - 1'b1;
                    if (last_iter) begin
                        result  <= acc_lo_n;
                        hi      <= acc_hi_n;
                        zero    <= (acc_lo_n == '0);
                        invalid <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and random operations against an arithmetic model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        busy;
    logic        done;
    logic        invalid;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_res = '0;

    alu_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .result     (result),
        .hi         (hi),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected outcome of one operation, from the opcode table
    task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [31:0] h,
                         output logic z, output logic inv, output int lat);
        logic [63:0] p;
        r = '0; h = '0; inv = 1'b0; lat = 1;
        case (op)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = x + y;
            4'd6: r = x - y;
            4'd3: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; lat = 33; end
            4'd4: begin
                if (y == 0) begin r = 32'hFFFF_FFFF; h = x; end
                else begin r = x / y; h = x % y; lat = 33; end
            end
            4'd5: r = x << y[4:0];
            4'd7: r = x >> y[4:0];
            4'd8: r = ~x;
            default: inv = 1'b1;
        endcase
        z = (r == 0);
    endtask

    // Issue one op; optionally pulse an ADD start poke_at cycles into it
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] va, input logic [31:0] vb, input int poke_at);
        logic [31:0] er, eh;
        logic        ez, ei;
        int          el, cyc, nbusy;
        logic        held;
        model(op, va, vb, er, eh, ez, ei, el);
        alucontrol = op; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        alucontrol = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
        cyc = 1; nbusy = 0; held = 1'b1;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            if (result !== last_res) held = 1'b0;
            if (poke_at != 0 && cyc == poke_at) begin
                alucontrol = 4'b0010; a = 32'd5; b = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(cyc), 64'(el));
        check({name, " busy_cycles"}, 64'(nbusy), 64'(el - 1));
        if (el > 1) check({name, " result_held"}, 64'(held), 64'd1);
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " result"}, 64'(result), 64'(er));
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " zero"}, 64'(zero), 64'(ez));
        check({name, " invalid"}, 64'(invalid), 64'(ei));
        last_res = er;
    endtask

    task automatic expect_quiet_cycle(input string name);
        @(posedge clk); #1;
        check({name, " done_one_cycle"}, 64'(done), 64'd0);
        check({name, " result_stable"}, 64'(result), 64'(last_res));
    endtask

    initial begin
        int ndone;
        logic [3:0]  op;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; alucontrol = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", 64'(result), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset flags", {60'd0, zero, busy, done, invalid}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add5_7", 4'b0010, 32'd5, 32'd7, 0);
        expect_quiet_cycle("add5_7");
        run_op("sub9_9", 4'b0110, 32'd9, 32'd9, 0);
        run_op("mult_ignore", 4'b0011, 32'hFFFF_FFFF, 32'd2, 5);
        expect_quiet_cycle("mult_ignore");
        run_op("div100_7", 4'b0100, 32'd100, 32'd7, 0);
        run_op("div_by0", 4'b0100, 32'd55, 32'd0, 0);
        run_op("mult_big", 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // abort a divide part way through
        alucontrol = 4'b0100; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort result", 64'(result), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort flags", {60'd0, zero, busy, done, invalid}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("abort no_done", 64'(ndone), 64'd0);
        last_res = '0;

        run_op("sll1_31", 4'b0101, 32'd1, 32'd31, 0);
        run_op("bad_code", 4'b1111, 32'd3, 32'd4, 0);
        run_op("or3_4", 4'b0001, 32'd3, 32'd4, 0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == 4'b0100 && $urandom_range(0, 1) == 1) rb = rb & 32'hFF;
            run_op("random", op, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to execute one operation with current inputs.
REQ-005 The block SHALL have port alucontrol  input  4  operation code produced by the ALU decoder.
REQ-006 The block SHALL have port a  input  32  operand A: dividend, multiplicand, or shifted value.
REQ-007 The block SHALL have port b  input  32  operand B: divisor or multiplier; b[4:0] is the shift amount.
REQ-008 The block SHALL have port result  output  32  registered result: low product word for MULT, quotient for DIV.
REQ-009 The block SHALL have port hi  output  32  registered high product word for MULT, remainder for DIV, 0 otherwise.
REQ-010 The block SHALL have port zero  output  1  registered flag, 1 when result == 0.
REQ-011 The block SHALL have port busy  output  1  1 while an iterative operation is in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse marking result/hi/zero/invalid valid.
REQ-013 The block SHALL have port invalid  output  1  registered flag, 1 when the completed code was unrecognised.

Function
REQ-014 The codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 MULT, 0100 DIV, 0101 SLL, 0111 SRL, 1000 NOT; all others are invalid.
REQ-015 The state machine SHALL have exactly the states IDLE, MUL and DIV.
REQ-016 The block SHALL accept start only in IDLE, latching alucontrol, a and b on that edge; start in MUL/DIV SHALL be ignored, with no queuing.
REQ-017 Single-cycle ops (AND, OR, ADD, SUB, SLL, SRL, NOT, invalid) SHALL update result, hi=0, zero and invalid and pulse done in the cycle after the accepting edge, with busy never asserted.
REQ-018 ADD/SUB SHALL be modulo 2^32 with no overflow flag; SLL/SRL SHALL be logical shifts by b[4:0]; NOT SHALL be ~a, ignoring b.
REQ-019 An invalid code SHALL give result=0, hi=0, zero=1, invalid=1 with done pulsed after 1 cycle; all valid codes SHALL clear invalid.
REQ-020 MULT SHALL be unsigned 32x32->64 shift-add, one multiplier bit per cycle, with hi:result = a*b.
REQ-021 DIV SHALL be unsigned restoring division, one quotient bit per cycle, with result = a/b and hi = a%b.
REQ-022 For MULT/DIV, the block SHALL move IDLE->MUL/DIV on the accepting edge and hold busy=1 for exactly 32 cycles, then return to IDLE with done=1 and busy=0 in the 33rd cycle after the accepting edge.
REQ-023 DIV with b==0 SHALL NOT enter DIV; it SHALL complete as a single-cycle op with result=32'hFFFFFFFF, hi=a and zero=0.
REQ-024 result, hi, zero and invalid SHALL hold their last values until the next completion and SHALL NOT change during busy.
REQ-025 start asserted in the same cycle that done pulses SHALL be accepted, because the state is IDLE.
REQ-026 done SHALL never be high for two consecutive cycles from a single start.

Reset
REQ-027 When reset is sampled high, state SHALL become IDLE and result=0, hi=0, zero=0, busy=0, done=0 and invalid=0 on that edge.
REQ-028 Reset SHALL take priority over start; a reset during MUL/DIV SHALL abort the operation and produce no done pulse.

Verification
REQ-029 ADD a=5, b=7 -> next cycle done=1, result=12, zero=0; SUB a=9, b=9 -> result=0, zero=1.
REQ-030 MULT a=32'hFFFFFFFF, b=2 -> busy 32 cycles, then done with hi=1, result=32'hFFFFFFFE.
REQ-031 DIV a=100, b=7 -> done after 33 cycles with result=14, hi=2; DIV b=0, a=55 -> next cycle result=32'hFFFFFFFF, hi=55, busy never 1.
REQ-032 A second start with ADD during MULT busy -> ignored; only the MULT completes and result is unchanged until then.
REQ-033 Reset asserted at cycle 10 of DIV -> next cycle all outputs 0, state IDLE, no done; a following SLL a=1, b=31 -> result=32'h80000000.
REQ-034 alucontrol=1111 -> done after 1 cycle, invalid=1, result=0; a following OR 3|4 -> result=7, invalid=0.
